fetch_stage: RTL and testbench

Program-counter and IF/ID pipeline-register block for the 3PA fetch stage. Drives address and enable into the instruction ROM, captures the returned word with its PC into the fetch/decode register, and handles stalls from decode, branch redirects from execute, ROM misses and misaligned branch targets. Sits between the execute-stage branch logic and the decode stage, wrapping the instruction memory.

---
 rtl/fetch_stage.sv | 93 +++++++++
 tb/tb_fetch_stage.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - program counter and IF/ID register for the fetch stage
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Stall,
    input  logic             Branch_taken,
    input  logic [31:0]      Branch_target,
    output logic [31:0]      Rom_addr,
    output logic             Rom_en,
    input  logic [31:0]      Rom_data,
    input  logic             Imiss,
    output logic [31:0]      Inst_out,
    output logic [31:0]      Pc_out,
    output logic             Valid_out,
    output logic             Misalign,
    output logic [CNT_W-1:0] Miss_cycles
);

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        MISS = 2'd2,
        HALT = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;

    logic fetching;
    logic target_aligned;

    assign fetching       = (state == RUN) || (state == MISS);
    assign target_aligned = (Branch_target[1:0] == 2'b00);

    // ROM is addressed straight from the PC; reads are suppressed whenever
    // decode is stalled or the stage is not actively fetching.
    assign Rom_addr = pc;
    assign Rom_en   = !Rst && !Stall && fetching;

    // PC, state machine, IF/ID register and the saturating miss counter.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc          <= RESET_PC;
            state       <= BOOT;
            Inst_out    <= 32'h0;
            Pc_out      <= 32'h0;
            Valid_out   <= 1'b0;
            Misalign    <= 1'b0;
            Miss_cycles <= '0;
        end else begin
            case (state)
                BOOT: begin
                    state <= RUN;
                end
                RUN, MISS: begin
                    // A cycle spent waiting on the ROM counts even when a
                    // redirect arrives in that same cycle.
                    if (state == MISS && !Stall && Miss_cycles != '1) begin
                        Miss_cycles <= Miss_cycles + CNT_W'(1);
                    end
                    if (Branch_taken) begin
                        Valid_out <= 1'b0;
                        if (target_aligned) begin
                            pc    <= Branch_target;
                            state <= RUN;
                        end else begin
                            Misalign <= 1'b1;
                            state    <= HALT;
                        end
                    end else if (!Stall) begin
                        if (Imiss) begin
                            Valid_out <= 1'b0;
                            state     <= MISS;
                        end else begin
                            Inst_out  <= Rom_data;
                            Pc_out    <= pc;
                            Valid_out <= 1'b1;
                            pc        <= pc + 32'd4;
                            state     <= RUN;
                        end
                    end
                end
                default: begin
                    Valid_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic        imiss;

    logic [31:0] addr0, addr1, data0, data1, inst0, inst1, pco0, pco1;
    logic        en0, en1, val0, val1, mis0, mis1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return (~a) ^ 32'h1234_5678;
    endfunction

    assign data0 = mem(addr0);
    assign data1 = mem(addr1);

    fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(16)) u0 (
        .Clk(clk), .Rst(rst), .Stall(stall), .Branch_taken(br), .Branch_target(tgt),
        .Rom_addr(addr0), .Rom_en(en0), .Rom_data(data0), .Imiss(imiss),
        .Inst_out(inst0), .Pc_out(pco0), .Valid_out(val0), .Misalign(mis0),
        .Miss_cycles(cnt0)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .CNT_W(2)) u1 (
        .Clk(clk), .Rst(rst), .Stall(stall), .Branch_taken(br), .Branch_target(tgt),
        .Rom_addr(addr1), .Rom_en(en1), .Rom_data(data1), .Imiss(imiss),
        .Inst_out(inst1), .Pc_out(pco1), .Valid_out(val1), .Misalign(mis1),
        .Miss_cycles(cnt1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Behavioural model: one entry per instance.
    localparam int M_BOOT = 0, M_FETCH = 1, M_WAIT = 2, M_DEAD = 3;
    logic [31:0] m_rpc   [2] = '{32'h0000_0000, 32'hFFFF_FFFC};
    int          m_cap   [2] = '{65535, 3};
    logic [31:0] m_pc    [2];
    int          m_mode  [2];
    logic [31:0] m_inst  [2];
    logic [31:0] m_pco   [2];
    logic        m_valid [2];
    logic        m_mis   [2];
    int          m_cnt   [2];
    bit          m_init = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pc[i] = m_rpc[i]; m_mode[i] = M_BOOT; m_inst[i] = 0; m_pco[i] = 0;
                m_valid[i] = 0; m_mis[i] = 0; m_cnt[i] = 0;
            end else if (m_mode[i] == M_BOOT) begin
                m_mode[i] = M_FETCH;
            end else if (m_mode[i] == M_FETCH || m_mode[i] == M_WAIT) begin
                if (m_mode[i] == M_WAIT && !stall) m_cnt[i] = (m_cnt[i] < m_cap[i]) ? m_cnt[i] + 1 : m_cap[i];
                if (br) begin
                    m_valid[i] = 0;
                    if (tgt % 4 == 0) begin m_pc[i] = tgt; m_mode[i] = M_FETCH; end
                    else begin m_mis[i] = 1; m_mode[i] = M_DEAD; end
                end else if (!stall) begin
                    if (imiss) begin m_valid[i] = 0; m_mode[i] = M_WAIT; end
                    else begin
                        m_inst[i] = mem(m_pc[i]); m_pco[i] = m_pc[i]; m_valid[i] = 1;
                        m_pc[i] = 32'(m_pc[i] + 64'd4); m_mode[i] = M_FETCH;
                    end
                end
            end
        end
        if (rst) m_init = 1;
    end

    // Compare process: every output of both instances, every cycle after reset.
    always @(negedge clk) begin
        if (m_init) begin
            for (int i = 0; i < 2; i++) begin
                logic exp_en;
                exp_en = !rst && !stall && (m_mode[i] == M_FETCH || m_mode[i] == M_WAIT);
                chk($sformatf("u%0d.rom_addr", i), i == 0 ? addr0 : addr1, m_pc[i]);
                chk($sformatf("u%0d.rom_en", i), {31'b0, i == 0 ? en0 : en1}, {31'b0, exp_en});
                chk($sformatf("u%0d.inst", i), i == 0 ? inst0 : inst1, m_inst[i]);
                chk($sformatf("u%0d.pc_out", i), i == 0 ? pco0 : pco1, m_pco[i]);
                chk($sformatf("u%0d.valid", i), {31'b0, i == 0 ? val0 : val1}, {31'b0, m_valid[i]});
                chk($sformatf("u%0d.misalign", i), {31'b0, i == 0 ? mis0 : mis1}, {31'b0, m_mis[i]});
                chk($sformatf("u%0d.miss_cycles", i), i == 0 ? {16'b0, cnt0} : {30'b0, cnt1}, 32'(m_cnt[i]));
            end
        end
    end

    // Apply one cycle of inputs, then land 1 time unit after the edge.
    task automatic cyc(input logic r, input logic s, input logic b, input logic [31:0] t, input logic m);
        rst = r; stall = s; br = b; tgt = t; imiss = m;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; stall = 0; br = 0; tgt = 0; imiss = 0;
        cyc(1, 0, 0, 0, 0);
        chk("reset_valid", {31'b0, val0}, 32'd0);
        chk("reset_pc_out", pco0, 32'h0);
        cyc(0, 0, 1, 32'h40, 0);             // BOOT: branch ignored
        chk("boot_addr", addr0, 32'h0);
        cyc(0, 0, 0, 0, 0);                  // capture A
        chk("first_valid", {31'b0, val0}, 32'd1);
        chk("first_inst", inst0, 32'hEDCB_A987);
        chk("first_pc", pco0, 32'h0);
        chk("wrap_pc_hi", pco1, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 0);                  // capture B
        chk("second_inst", inst0, 32'hEDCB_A983);
        chk("wrap_pc_lo", pco1, 32'h0000_0000);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 0, 0, 0);
            chk("stall_hold_pc", pco0, 32'h4);
        end
        cyc(0, 0, 0, 0, 1);                  // RUN -> MISS
        chk("miss_bubble", {31'b0, val0}, 32'd0);
        chk("miss_addr", addr0, 32'h8);
        chk("miss_cnt0", {16'b0, cnt0}, 32'd0);
        cyc(0, 0, 0, 0, 1);
        chk("miss_cnt1", {16'b0, cnt0}, 32'd1);
        cyc(0, 0, 0, 0, 0);                  // capture C
        chk("miss_cnt2", {16'b0, cnt0}, 32'd2);
        chk("after_miss_inst", inst0, 32'hEDCB_A98F);
        chk("after_miss_pc", pco0, 32'h8);
        cyc(0, 0, 0, 0, 0);                  // capture D
        chk("d_pc", pco0, 32'hC);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1);
        cyc(0, 1, 0, 0, 1);                  // stalled miss cycle is not counted
        chk("stalled_miss_cnt", {16'b0, cnt0}, 32'd4);
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0);
        chk("long_miss_cnt", {16'b0, cnt0}, 32'd8);
        chk("sat_cnt", {30'b0, cnt1}, 32'd3);
        cyc(0, 1, 1, 32'h40, 1);             // branch beats stall and miss
        chk("br_addr", addr0, 32'h40);
        chk("br_squash", {31'b0, val0}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        chk("br_inst", inst0, 32'hEDCB_A9C7);
        chk("br_pc", pco0, 32'h40);
        cyc(0, 0, 0, 0, 1);                  // enter MISS
        cyc(0, 1, 1, 32'h80, 1);             // redirect abandons the miss
        cyc(0, 0, 0, 0, 0);
        chk("br_from_miss_pc", pco0, 32'h80);
        chk("br_from_miss_valid", {31'b0, val0}, 32'd1);
        cyc(0, 0, 1, 32'h42, 0);             // misaligned target
        chk("misalign_set", {31'b0, mis0}, 32'd1);
        chk("misalign_squash", {31'b0, val0}, 32'd0);
        cyc(0, 0, 1, 32'h100, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1);
        chk("halt_addr", addr0, 32'h84);
        chk("halt_valid", {31'b0, val0}, 32'd0);
        cyc(1, 0, 0, 0, 0);
        chk("misalign_clear", {31'b0, mis0}, 32'd0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("restart_pc", pco0, 32'h0);
        chk("restart_valid", {31'b0, val0}, 32'd1);
        cyc(0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1);
        cyc(1, 0, 0, 0, 1);                  // reset mid-miss
        chk("midmiss_reset_cnt", {16'b0, cnt0}, 32'd0);
        for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 0);
        chk("final_pc", pco0, 32'h8);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
